ahb_master_sequencer: RTL and testbench



---
 rtl/ahb_master_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_ahb_master_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_sequencer.sv
// Command-driven AHB request sequencer: turns one (addr, len, dir) command into a
// SINGLE or INCR beat stream with BUSY insertion, 1 KB restarts and re-grant restarts.
module ahb_master_sequencer #(
  parameter int unsigned WDT = 32,
  parameter int unsigned LW  = 8
) (
  input  logic           i_hclk,
  input  logic           i_hreset,
  input  logic           i_hready,
  input  logic           i_hgrant,
  input  logic           i_cmd_valid,
  output logic           o_cmd_ready,
  input  logic [31:0]    i_cmd_addr,
  input  logic [LW-1:0]  i_cmd_len,
  input  logic           i_cmd_write,
  input  logic [1:0]     i_cmd_size,
  input  logic [3:0]     i_cmd_prot,
  input  logic           i_cmd_lock,
  input  logic [WDT-1:0] i_wr_data,
  input  logic           i_wr_valid,
  output logic           o_wr_ready,
  output logic           o_hwrite,
  output logic [WDT-1:0] o_hwdata,
  output logic [31:0]    o_haddr,
  output logic [1:0]     o_htrans,
  output logic [1:0]     o_hburst,
  output logic [1:0]     o_hsize,
  output logic [3:0]     o_hprot,
  output logic           o_hlock,
  output logic           o_hbusreq,
  output logic           o_busy,
  output logic           o_done
);

  localparam logic [1:0] HtIdle   = 2'd0;
  localparam logic [1:0] HtBusy   = 2'd1;
  localparam logic [1:0] HtNonseq = 2'd2;
  localparam logic [1:0] HtSeq    = 2'd3;
  localparam logic [1:0] HbSingle = 2'd0;
  localparam logic [1:0] HbIncr   = 2'd1;

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StWait} state_e;

  state_e         state_q, state_d;
  logic [LW:0]    remaining_q, remaining_d;
  logic [31:0]    cmd_addr_q, cmd_addr_d;
  logic           cmd_incr_q, cmd_incr_d;
  logic           cmd_write_q, cmd_write_d;
  logic [1:0]     cmd_size_q, cmd_size_d;
  logic [3:0]     cmd_prot_q, cmd_prot_d;

  logic           hwrite_q, hwrite_d;
  logic [WDT-1:0] hwdata_q, hwdata_d;
  logic [31:0]    haddr_q, haddr_d;
  logic [1:0]     htrans_q, htrans_d;
  logic [1:0]     hburst_q, hburst_d;
  logic [1:0]     hsize_q, hsize_d;
  logic [3:0]     hprot_q, hprot_d;
  logic           hlock_q, hlock_d;
  logic           hbusreq_q, hbusreq_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           adv;
  logic           cmd_ready;
  logic           wr_ready;
  logic [31:0]    next_addr;
  logic [1:0]     next_trans;
  logic [1:0]     resume_trans;
  logic           beat_live;

  assign adv       = i_hready && i_hgrant;
  assign beat_live = (htrans_q == HtNonseq) || (htrans_q == HtSeq);
  assign next_addr = haddr_q + (32'd1 << hsize_q);
  // Crossing a 1 KB page restarts the burst with NONSEQ.
  assign next_trans = (next_addr[31:10] != haddr_q[31:10]) ? HtNonseq : HtSeq;
  // In WAIT haddr_q already holds the next aligned address; it sits on a new
  // 1 KB page exactly when its low ten bits are zero.
  assign resume_trans = (haddr_q[9:0] == 10'd0) ? HtNonseq : HtSeq;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_incr_d  = cmd_incr_q;
    cmd_write_d = cmd_write_q;
    cmd_size_d  = cmd_size_q;
    cmd_prot_d  = cmd_prot_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hburst_d    = hburst_q;
    hsize_d     = hsize_q;
    hprot_d     = hprot_q;
    hlock_d     = hlock_q;
    hbusreq_d   = hbusreq_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wr_ready    = 1'b0;
    // A stalled bus (hready low) freezes everything, including acceptance.
    cmd_ready   = (state_q == StIdle) && i_hready;

    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid && cmd_ready) begin
          cmd_addr_d  = i_cmd_addr;
          cmd_incr_d  = (i_cmd_len != '0);
          cmd_write_d = i_cmd_write;
          cmd_size_d  = i_cmd_size;
          cmd_prot_d  = i_cmd_prot;
          remaining_d = {1'b0, i_cmd_len} + (LW + 1)'(1);
          hbusreq_d   = 1'b1;
          hlock_d     = i_cmd_lock;
          busy_d      = 1'b1;
          state_d     = StReq;
        end
      end

      StReq: begin
        if (adv && (!cmd_write_q || i_wr_valid)) begin
          wr_ready = cmd_write_q;
          htrans_d = HtNonseq;
          haddr_d  = cmd_addr_q;
          hburst_d = cmd_incr_q ? HbIncr : HbSingle;
          hsize_d  = cmd_size_q;
          hprot_d  = cmd_prot_q;
          hwrite_d = cmd_write_q;
          if (cmd_write_q) begin
            hwdata_d = i_wr_data;
          end
          state_d = StXfer;
        end
      end

      StXfer: begin
        if (adv && beat_live) begin
          remaining_d = remaining_q - (LW + 1)'(1);
          if (remaining_q == (LW + 1)'(1)) begin
            htrans_d  = HtIdle;
            hbusreq_d = 1'b0;
            hlock_d   = 1'b0;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = StIdle;
          end else if (!hwrite_q) begin
            htrans_d = next_trans;
            haddr_d  = next_addr;
          end else if (i_wr_valid) begin
            wr_ready = 1'b1;
            hwdata_d = i_wr_data;
            htrans_d = next_trans;
            haddr_d  = next_addr;
          end else begin
            htrans_d = HtBusy;
            haddr_d  = next_addr;
            state_d  = StWait;
          end
        end else if (i_hready && !i_hgrant && (htrans_q == HtSeq)) begin
          // Lost the bus mid-burst: the beat must restart as NONSEQ on re-grant.
          htrans_d = HtNonseq;
        end
      end

      StWait: begin
        if (adv && i_wr_valid) begin
          wr_ready = 1'b1;
          hwdata_d = i_wr_data;
          htrans_d = resume_trans;
          state_d  = StXfer;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      cmd_addr_q  <= '0;
      cmd_incr_q  <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_size_q  <= '0;
      cmd_prot_q  <= '0;
      hwrite_q    <= 1'b1;
      hwdata_q    <= '0;
      haddr_q     <= '0;
      htrans_q    <= HtIdle;
      hburst_q    <= HbSingle;
      hsize_q     <= '0;
      hprot_q     <= '0;
      hlock_q     <= 1'b0;
      hbusreq_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_incr_q  <= cmd_incr_d;
      cmd_write_q <= cmd_write_d;
      cmd_size_q  <= cmd_size_d;
      cmd_prot_q  <= cmd_prot_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hburst_q    <= hburst_d;
      hsize_q     <= hsize_d;
      hprot_q     <= hprot_d;
      hlock_q     <= hlock_d;
      hbusreq_q   <= hbusreq_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_cmd_ready = cmd_ready;
  assign o_wr_ready  = wr_ready;
  assign o_hwrite    = hwrite_q;
  assign o_hwdata    = hwdata_q;
  assign o_haddr     = haddr_q;
  assign o_htrans    = htrans_q;
  assign o_hburst    = hburst_q;
  assign o_hsize     = hsize_q;
  assign o_hprot     = hprot_q;
  assign o_hlock     = hlock_q;
  assign o_hbusreq   = hbusreq_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_ahb_master_sequencer.sv
// Scoreboard bench for ahb_master_sequencer: directed commands push hand-computed
// beats; a negedge monitor pops and compares every beat the pipeline accepts.
module tb_ahb_master_sequencer;

  localparam int WDT = 32;
  localparam int LW  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           hready = 1'b1;
  logic           hgrant = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [31:0]    cmd_addr = '0;
  logic [LW-1:0]  cmd_len = '0;
  logic           cmd_write = 1'b0;
  logic [1:0]     cmd_size = '0;
  logic [3:0]     cmd_prot = 4'h3;
  logic           cmd_lock = 1'b0;
  logic [WDT-1:0] wr_data = '0;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic           hwrite;
  logic [WDT-1:0] hwdata;
  logic [31:0]    haddr;
  logic [1:0]     htrans, hburst, hsize;
  logic [3:0]     hprot;
  logic           hlock, hbusreq, busy, done;

  always #5 clk = ~clk;

  ahb_master_sequencer #(.WDT(WDT), .LW(LW)) dut (
    .i_hclk(clk), .i_hreset(rst), .i_hready(hready), .i_hgrant(hgrant),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_addr(cmd_addr),
    .i_cmd_len(cmd_len), .i_cmd_write(cmd_write), .i_cmd_size(cmd_size),
    .i_cmd_prot(cmd_prot), .i_cmd_lock(cmd_lock), .i_wr_data(wr_data),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .o_hwrite(hwrite), .o_hwdata(hwdata),
    .o_haddr(haddr), .o_htrans(htrans), .o_hburst(hburst), .o_hsize(hsize),
    .o_hprot(hprot), .o_hlock(hlock), .o_hbusreq(hbusreq), .o_busy(busy), .o_done(done)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [1:0]  burst;
    logic        write;
    logic [31:0] data;
    logic [1:0]  size;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] wq[$];
  beat_t       mon_e;
  int          n_tests = 0, n_fail = 0;
  int          beats = 0, dones = 0, busy_adv = 0, wr_hs = 0;
  int          stall_at = -1, stall_len = 0, stall = 0;
  logic [31:0] exp_busy_addr = '0;
  logic        hs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_beat(input logic [31:0] a, input logic [1:0] t, input logic [1:0] b,
                          input logic w, input logic [31:0] d, input logic [1:0] s);
    beat_t e;
    e.addr = a; e.trans = t; e.burst = b; e.write = w; e.data = d; e.size = s;
    sb.push_back(e);
  endtask

  // Monitor: every accepted NONSEQ/SEQ beat is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) dones++;
      if (hready && hgrant && (htrans == 2'd2 || htrans == 2'd3)) begin
        beats++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got addr 0x%0h expected no beat", haddr);
        end else begin
          mon_e = sb.pop_front();
          check("beat_addr", haddr, mon_e.addr);
          check("beat_trans", {30'd0, htrans}, {30'd0, mon_e.trans});
          check("beat_burst", {30'd0, hburst}, {30'd0, mon_e.burst});
          check("beat_write", {31'd0, hwrite}, {31'd0, mon_e.write});
          check("beat_size", {30'd0, hsize}, {30'd0, mon_e.size});
          check("beat_prot", {28'd0, hprot}, 32'h3);
          if (mon_e.write) check("beat_wdata", hwdata, mon_e.data);
        end
      end
      if (hready && hgrant && htrans == 2'd1) begin
        busy_adv++;
        check("busy_addr", haddr, exp_busy_addr);
      end
    end
  end

  // Write-data source with an optional starvation window after a chosen handshake.
  initial begin
    forever begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      if (hs) wr_hs++;
      @(posedge clk);
      #1;
      if (hs) begin
        void'(wq.pop_front());
        if (wr_hs == stall_at) stall = stall_len;
      end
      if (stall > 0) begin
        wr_valid = 1'b0;
        stall--;
      end else begin
        wr_valid = (wq.size() > 0);
      end
      wr_data = (wq.size() > 0) ? wq[0] : '0;
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [7:0] len, input logic w,
                       input logic [1:0] s, input logic lk);
    int n = 0;
    tick();
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = len; cmd_write = w; cmd_size = s;
    cmd_lock = lk;
    do begin
      sample();
      n++;
    end while (!cmd_ready && n < 50);
    check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (dones < target && n < 600) begin
      sample();
      n++;
    end
    check(name, dones, target);
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats < target && n < 100) begin
      sample();
      n++;
    end
    check("wait_beats", beats, target);
  endtask

  int d0, b0, h0, k0;

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    sample();
    check("rst_htrans", {30'd0, htrans}, 32'd0);
    check("rst_hbusreq", {31'd0, hbusreq}, 32'd0);
    check("rst_hwrite", {31'd0, hwrite}, 32'd1);
    check("rst_haddr", haddr, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);

    // Single locked read
    d0 = dones;
    exp_beat(32'h100, 2'd2, 2'd0, 1'b0, 32'h0, 2'd2);
    issue(32'h100, 8'd0, 1'b0, 2'd2, 1'b1);
    sample();
    check("req_htrans", {30'd0, htrans}, 32'd0);
    check("req_hbusreq", {31'd0, hbusreq}, 32'd1);
    check("req_hlock", {31'd0, hlock}, 32'd1);
    check("req_busy", {31'd0, busy}, 32'd1);
    wait_done(d0 + 1, "single_done");
    check("single_end_htrans", {30'd0, htrans}, 32'd0);
    check("single_end_hbusreq", {31'd0, hbusreq}, 32'd0);
    check("single_end_hlock", {31'd0, hlock}, 32'd0);
    repeat (3) sample();
    check("single_done_once", dones, d0 + 1);
    check("single_busy_low", {31'd0, busy}, 32'd0);
    check("single_sb_empty", sb.size(), 32'd0);

    // Write INCR4, data always available
    d0 = dones; h0 = wr_hs;
    for (int i = 0; i < 4; i++) wq.push_back(32'hA000_0000 + i);
    exp_beat(32'h2000, 2'd2, 2'd1, 1'b1, 32'hA000_0000, 2'd2);
    exp_beat(32'h2004, 2'd3, 2'd1, 1'b1, 32'hA000_0001, 2'd2);
    exp_beat(32'h2008, 2'd3, 2'd1, 1'b1, 32'hA000_0002, 2'd2);
    exp_beat(32'h200C, 2'd3, 2'd1, 1'b1, 32'hA000_0003, 2'd2);
    tick();
    issue(32'h2000, 8'd3, 1'b1, 2'd2, 1'b0);
    wait_done(d0 + 1, "wr4_done");
    check("wr4_handshakes", wr_hs - h0, 32'd4);
    check("wr4_sb_empty", sb.size(), 32'd0);

    // Write INCR4 with write data starved for two cycles after beat 1
    d0 = dones; h0 = wr_hs; k0 = busy_adv;
    stall_at = wr_hs + 2; stall_len = 2; exp_busy_addr = 32'h2008;
    for (int i = 0; i < 4; i++) wq.push_back(32'hB000_0000 + i);
    exp_beat(32'h2000, 2'd2, 2'd1, 1'b1, 32'hB000_0000, 2'd2);
    exp_beat(32'h2004, 2'd3, 2'd1, 1'b1, 32'hB000_0001, 2'd2);
    exp_beat(32'h2008, 2'd3, 2'd1, 1'b1, 32'hB000_0002, 2'd2);
    exp_beat(32'h200C, 2'd3, 2'd1, 1'b1, 32'hB000_0003, 2'd2);
    tick();
    issue(32'h2000, 8'd3, 1'b1, 2'd2, 1'b0);
    wait_done(d0 + 1, "wrstall_done");
    check("wrstall_busy_cycles", busy_adv - k0, 32'd2);
    check("wrstall_handshakes", wr_hs - h0, 32'd4);
    check("wrstall_sb_empty", sb.size(), 32'd0);
    stall_at = -1;

    // Read across a 1 KB boundary
    d0 = dones;
    exp_beat(32'h3F8, 2'd2, 2'd1, 1'b0, 32'h0, 2'd2);
    exp_beat(32'h3FC, 2'd3, 2'd1, 1'b0, 32'h0, 2'd2);
    exp_beat(32'h400, 2'd2, 2'd1, 1'b0, 32'h0, 2'd2);
    exp_beat(32'h404, 2'd3, 2'd1, 1'b0, 32'h0, 2'd2);
    issue(32'h3F8, 8'd3, 1'b0, 2'd2, 1'b0);
    wait_done(d0 + 1, "kb_done");
    check("kb_sb_empty", sb.size(), 32'd0);

    // Grant withdrawn for three cycles after beat 0 of a 4-beat read
    d0 = dones; b0 = beats;
    exp_beat(32'h500, 2'd2, 2'd1, 1'b0, 32'h0, 2'd2);
    exp_beat(32'h504, 2'd2, 2'd1, 1'b0, 32'h0, 2'd2);
    exp_beat(32'h508, 2'd3, 2'd1, 1'b0, 32'h0, 2'd2);
    exp_beat(32'h50C, 2'd3, 2'd1, 1'b0, 32'h0, 2'd2);
    issue(32'h500, 8'd3, 1'b0, 2'd2, 1'b0);
    wait_beats(b0 + 1);
    tick();
    hgrant = 1'b0;
    sample();
    check("regrant_seq_before", {30'd0, htrans}, 32'd3);
    sample();
    check("regrant_nonseq", {30'd0, htrans}, 32'd2);
    sample();
    check("regrant_addr_held", haddr, 32'h504);
    check("regrant_busreq", {31'd0, hbusreq}, 32'd1);
    check("regrant_frozen", beats, b0 + 1);
    tick();
    hgrant = 1'b1;
    wait_done(d0 + 1, "regrant_done");
    check("regrant_beats", beats - b0, 32'd4);

    // Address wrap at 2^32 (also a page change)
    d0 = dones;
    exp_beat(32'hFFFF_FFFC, 2'd2, 2'd1, 1'b0, 32'h0, 2'd2);
    exp_beat(32'h0000_0000, 2'd2, 2'd1, 1'b0, 32'h0, 2'd2);
    issue(32'hFFFF_FFFC, 8'd1, 1'b0, 2'd2, 1'b0);
    wait_done(d0 + 1, "wrap_done");

    // Maximum burst: 256 byte beats
    d0 = dones; b0 = beats;
    for (int i = 0; i < 256; i++)
      exp_beat(32'hF00 + i, (i == 0) ? 2'd2 : 2'd3, 2'd1, 1'b0, 32'h0, 2'd0);
    issue(32'hF00, 8'hFF, 1'b0, 2'd0, 1'b0);
    wait_done(d0 + 1, "max_done");
    check("max_beats", beats - b0, 32'd256);

    // Reset mid-burst, then a normal single write
    b0 = beats;
    exp_beat(32'h600, 2'd2, 2'd1, 1'b0, 32'h0, 2'd2);
    issue(32'h600, 8'd3, 1'b0, 2'd2, 1'b0);
    wait_beats(b0 + 1);
    tick();
    rst = 1'b1;
    d0 = dones;
    tick();
    rst = 1'b0;
    sb.delete();
    sample();
    check("midrst_htrans", {30'd0, htrans}, 32'd0);
    check("midrst_hbusreq", {31'd0, hbusreq}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    repeat (4) sample();
    check("midrst_no_done", dones, d0);
    wq.push_back(32'h5A5A_5A5A);
    exp_beat(32'h40, 2'd2, 2'd0, 1'b1, 32'h5A5A_5A5A, 2'd2);
    tick();
    issue(32'h40, 8'd0, 1'b1, 2'd2, 1'b0);
    wait_done(d0 + 1, "postrst_done");
    check("postrst_sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
